// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state encoding and register reset values.
package lsu_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  localparam logic [31:0] RST_WORD = 32'h0000_0000;
  localparam logic [15:0] RST_CNT  = 16'h0000;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: byte enables,
// store-data replication, load lane select plus sign/zero extension,
// and the misalignment flag (only raised when LSU_MISALIGN_EXC_EN is defined).
// Size 2'b11 is reserved and behaves as a word access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane decode per access size; word (and reserved) passes through.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    byte_lane = rdata[{off, 3'b000} +: 8];
    half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      LSU_SIZE_B: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      end
      LSU_SIZE_H: begin
        be        = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      end
      default: begin
        be        = 4'b1111;
      end
    endcase
  end

`ifdef LSU_MISALIGN_EXC_EN
  // Half needs addr[0]=0; word (and reserved) needs addr[1:0]=0.
  always_comb begin
    misalign = ((size == LSU_SIZE_H) && off[0]) || (size[1] && (off != 2'b00));
  end
`else
  // Low address bits below the access size are simply dropped.
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op from EX, drives a word-aligned
// req/ack memory port, and returns one rsp_valid pulse per accepted op.
// Handshake: an op is accepted on a rising edge where req_valid=1 and
// req_ready=1; mem_req stays high until the edge that samples mem_ack=1
// or the timeout fires; rsp_valid is a single-cycle pulse, no back-pressure.
// Optional: LSU_MISALIGN_EXC_EN turns misaligned half/word accesses into
// immediate error responses without touching memory.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output lsu_state_e  fsm_state
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  lsu_state_e  state_q, state_n;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [15:0] cnt_q;
  logic        accept, ack_done, to_done, misalign;
  logic [1:0]  size_sel, off_sel;
  logic [3:0]  be;
  logic [31:0] wdata_rep, rdata_ext;

  // In IDLE the lane logic looks at the incoming request so the
  // misalignment decision is available at accept time.
  assign size_sel = (state_q == ST_IDLE) ? req_size      : size_q;
  assign off_sel  = (state_q == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .size        (size_sel),
    .is_unsigned (uns_q),
    .off         (off_sel),
    .wdata       (wdata_q),
    .rdata       (mem_rdata),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  // Next state and transaction events; ack has priority over timeout.
  always_comb begin
    state_n  = state_q;
    accept   = 1'b0;
    ack_done = 1'b0;
    to_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_n = misalign ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          ack_done = 1'b1;
          state_n  = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          to_done = 1'b1;
          state_n = ST_RESP;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Request capture, timeout counter and response registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= LSU_SIZE_B;
      addr_q  <= RST_WORD;
      wdata_q <= RST_WORD;
      rdata_q <= RST_WORD;
      err_q   <= 1'b0;
      cnt_q   <= RST_CNT;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt_q   <= RST_CNT;
        err_q   <= misalign;
        rdata_q <= RST_WORD;
      end
      if ((state_q == ST_REQ) && !ack_done && !to_done) cnt_q <= cnt_q + 16'd1;
      if (ack_done) begin
        err_q   <= 1'b0;
        rdata_q <= we_q ? RST_WORD : rdata_ext;
      end
      if (to_done) begin
        err_q   <= 1'b1;
        rdata_q <= RST_WORD;
      end
    end
  end

  assign req_ready = rstn && (state_q == ST_IDLE);
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_be    = mem_req ? be : 4'b0000;
  assign mem_wdata = mem_req ? wdata_rep : RST_WORD;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_valid & err_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed scenarios plus randomized accesses, checked
// against a byte-lane model of loads/stores and a response queue.
// Runs with TIMEOUT=6 so a 5-cycle-late ack lands exactly on the timeout cycle.
module tb_lsu;
  import lsu_pkg::*;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        req_ready, mem_req, mem_we, rsp_valid, rsp_err;
  logic [31:0] mem_addr, mem_wdata, rsp_rdata;
  logic [3:0]  mem_be;
  lsu_state_e  fsm_state;

  // Clock
  always #5 clk = ~clk;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .fsm_state(fsm_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];
  logic [32:0] e_rsp;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0;
  logic [3:0]  e_be = 4'h0;
  logic        e_we = 1'b0;
  logic        chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_len(input logic [1:0] size);
    case (size)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // First byte lane of the naturally aligned container holding the access.
  function automatic int m_start(input logic [1:0] size, input logic [31:0] addr);
    int len;
    len = m_len(size);
    return (int'(addr[1:0]) / len) * len;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    logic [3:0] be;
    int st, len;
    be = 4'h0;
    st = m_start(size, addr);
    len = m_len(size);
    for (int b = 0; b < 4; b++) if (b >= st && b < st + len) be[b] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] w;
    int len;
    len = m_len(size);
    w = 32'h0;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = wdata[8*(b % len) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v, mask;
    int len;
    len = m_len(size);
    v = rdata >> (8 * m_start(size, addr));
    if (len < 4) begin
      mask = (32'h1 << (8 * len)) - 32'h1;
      v = v & mask;
      if (!uns && v[8*len-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic m_misalign(input logic [1:0] size, input logic [31:0] addr);
    logic r;
    r = (int'(addr[1:0]) % m_len(size)) != 0;
`ifdef LSU_MISALIGN_EXC_EN
    return r;
`else
    return r & 1'b0;
`endif
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", 32'(mem_be), 32'(e_be));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        chk("req_ready_in_req", 32'(req_ready), 32'd0);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
        end else begin
          e_rsp = exp_q.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(e_rsp[32]));
          chk("rsp_rdata", rsp_rdata, e_rsp[31:0]);
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output bit ok);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    ok = req_ready;
    if (!ok) chk("ready_wait", 32'(req_ready), 32'd1);
  endtask

  // One access; delay = REQ cycle index (0-based) that gets the ack, <0 = never.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input logic [31:0] rdata);
    int k, nreq, exp_req;
    logic mis, to;
    bit done, ok;
    mis = m_misalign(size, addr);
    to = !mis && (delay < 0 || delay >= TO);
    exp_req = mis ? 0 : (to ? TO : delay + 1);
    wait_ready(ok);
    if (!ok) return;
    e_addr  = addr & ~32'h3;
    e_be    = m_be(size, addr);
    e_we    = we;
    e_wdata = m_wdata(size, wdata);
    if (mis || to) exp_q.push_back({1'b1, 32'h0});
    else           exp_q.push_back({1'b0, we ? 32'h0 : m_load(size, uns, addr, rdata)});
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    mem_ack = 1'($urandom_range(0, 1));
    nreq = 0; done = 0; k = 0;
    while (!done && k < 64) begin
      @(negedge clk);
      k++;
      req_valid = 1'b0;
      req_addr  = $urandom();
      req_wdata = $urandom();
      if (rsp_valid) begin
        done = 1;
        mem_ack = 1'($urandom_range(0, 1));
      end else if (mem_req) begin
        mem_ack   = (nreq == delay);
        mem_rdata = (nreq == delay) ? rdata : $urandom();
        nreq++;
      end else begin
        mem_ack = 1'b0;
      end
    end
    chk("rsp_seen", 32'(done), 32'd1);
    chk("mem_req_cycles", 32'(nreq), 32'(exp_req));
    chk("latency", 32'(k), 32'(exp_req + 1));
  endtask

  // Reset during REQ, then a late ack: no response may appear.
  task automatic reset_mid();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    e_addr = 32'h0000_5000; e_be = 4'hF; e_we = 1'b0; e_wdata = 32'h0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_5000;
    mem_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mem_req_before", 32'(mem_req), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_mem_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_rsp", 32'(rsp_valid), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] sz;
    int dl;
    // reset block
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req0", 32'(mem_req), 32'd0);
    chk("rst_mem_we0", 32'(mem_we), 32'd0);
    chk("rst_mem_be0", 32'(mem_be), 32'd0);
    chk("rst_mem_addr0", mem_addr, 32'd0);
    chk("rst_mem_wdata0", mem_wdata, 32'd0);
    chk("rst_rsp_valid0", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err0", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata0", rsp_rdata, 32'd0);
    chk("rst_req_ready0", 32'(req_ready), 32'd0);
    chk("rst_state0", 32'(fsm_state), 32'(ST_IDLE));
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(req_ready), 32'd1);
    chk_en = 1'b1;

    // hand-computed pins on the model
    chk("pin_be_b3", 32'(m_be(2'b00, 32'h1003)), 32'h8);
    chk("pin_wdata_b", m_wdata(2'b00, 32'h0000_00AB), 32'hABAB_ABAB);
    chk("pin_lh_s", m_load(2'b01, 1'b0, 32'h2002, 32'h8001_1234), 32'hFFFF_8001);
    chk("pin_lh_u", m_load(2'b01, 1'b1, 32'h2002, 32'h8001_1234), 32'h0000_8001);
    chk("pin_lb_s1", m_load(2'b00, 1'b0, 32'h0001, 32'h0000_9C00), 32'hFFFF_FF9C);

    // directed scenarios
    access(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0);
    access(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 0, 32'h8001_1234);
    access(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 0, 32'h8001_1234);
    access(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 5, 32'hCAFE_F00D);
    access(1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'h0, -1, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 0, 32'hDEAD_BEEF);
    access(1'b1, 2'b01, 1'b0, 32'h0000_4003, 32'h0000_BEEF, 1, 32'h0);
    reset_mid();

    // randomized accesses with random idle gaps and stray acks
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      dl = $urandom_range(0, 9);
      if (dl == 9) dl = -1;
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom(),
             $urandom(), dl, $urandom());
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        mem_ack = 1'($urandom_range(0, 1));
      end
    end

    mem_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the EX stage's ALU and the data-memory port. Takes the ALU result as effective address plus the rt value and access size, then drives a word-aligned request/acknowledge memory interface with byte enables. Returns sign- or zero-extended load data, or completes stores. It stalls the core through `req_ready` while a transaction is outstanding.

## Interface
- `TIMEOUT`, 256: cycles `mem_req` may stay high without `mem_ack` before the access is aborted; legal range 2..65535.
- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `req_valid` in 1: EX stage presents a memory operation.
- `req_ready` out 1: LSU can accept; low means the core stalls.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `req_unsigned` in 1: zero-extend load result (LBU/LHU); ignored for word and stores.
- `req_addr` in 32: effective address (ALU result).
- `req_wdata` in 32: store data, right-aligned.
- `mem_req` out 1: memory request, held until ack or timeout.
- `mem_we` out 1: memory write.
- `mem_addr` out 32: `{addr[31:2], 2'b00}`.
- `mem_be` out 4: byte enables, little-endian lanes.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory completed the access this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ack`=1.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: access aborted; qualified by `rsp_valid`.

## Operation
- FSM states: IDLE, REQ, RESP. Reset enters IDLE.
- IDLE: `req_ready`=1. On `req_valid`, register we, size, unsigned, addr, wdata; go to REQ and clear the timeout counter.
- REQ: `mem_req`=1, and `mem_we/addr/be/wdata` are held stable from registers.
  - On `mem_ack`: latch the extracted `mem_rdata` (loads) and go to RESP with err=0.
  - On counter reaching `TIMEOUT-1` with no ack: go to RESP with err=1 and rdata=0.
  - Ack and timeout in the same cycle: ack wins.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. `req_ready`=0 in REQ and RESP.
- Byte enables:
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `addr[1] ? 4'b1100 : 4'b0011`.
  - Word: `4'b1111`.
- Store data: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word unchanged.
- Load data: select lane by the registered `addr[1:0]` (byte) or `addr[1]` (half), then extend.
  - Sign extension uses bit 7 or bit 15 unless `req_unsigned`.
  - Word loads pass through unchanged.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset values: `mem_req`, `mem_we`, `mem_be`, `rsp_valid`, `rsp_err` = 0; `mem_addr`, `mem_wdata`, `rsp_rdata` = 0; `req_ready`=0 while `rstn`=0, and 1 from the first cycle after release.
- Accept at edge E0; `mem_req` high in cycle E0+1.
- Ack sampled at edge Ek gives `rsp_valid` in cycle Ek+1.
- Minimum latency, with ack in the first REQ cycle: response 2 cycles after accept.
- Next accept no earlier than the cycle after RESP, so throughput is at most one access per 3 cycles.
- Reset asserted in REQ or RESP: IDLE at the next edge; `mem_req` and `rsp_valid` drop; no response is produced for the aborted access.
- A timeout with `mem_req` first high at cycle T drops `mem_req` after cycle T+TIMEOUT-1; `rsp_valid`/`rsp_err` are high at T+TIMEOUT.

## Configuration
- `LSU_MISALIGN_EXC_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, skips memory.
  - The FSM goes IDLE→RESP and produces `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0; `mem_req` is never asserted.
- Not defined: the ignored low address bits are dropped (half ignores `addr[0]`, word ignores `addr[1:0]`) and the access proceeds normally.
- `rsp_err` still reports timeouts in both builds.

## Structure
- Shared define include holds: size encodings `LSU_SIZE_B/H/W`, FSM state encodings, and the reset value constants.
- One sub-module, `lsu_align`, is purely combinational. It produces `mem_be`, replicated wdata, lane-selected/extended read data, and the misalignment flag from size, unsigned and `addr[1:0]`.
- The top level holds the FSM, the request registers and the timeout counter.

## Test plan
- Store byte, addr 0x1003, wdata 0xAB, ack on first REQ cycle → `mem_addr`=0x1000, `mem_be`=4'b1000, `mem_wdata`=0xABABABAB; `rsp_valid` 2 cycles after accept.
- Load half signed, addr 0x2002, `mem_rdata`=0x8001_1234 → `rsp_rdata`=0xFFFF8001; same access with unsigned → 0x00008001.
- Load word, addr 0x3000, ack delayed 5 cycles → `mem_req` high for 6 cycles, `rsp_rdata`=`mem_rdata`, `req_ready` low throughout.
- Timeout: `TIMEOUT`=4, no ack → `mem_req` high 4 cycles, then `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
- Word load at addr 0x4002 → with the macro: err response, `mem_req` never asserted; without the macro: `mem_addr`=0x4000, `mem_be`=4'b1111.
- Reset pulled low during REQ, then a late `mem_ack` → no `rsp_valid`; `mem_req`=0; `req_ready`=1 after release.
